// File: rtl/rv32_hart_scheduler_pkg.sv
// Shared types for the RV32 multi-hart front end: hart ids, hart run states, next-state rule.
// Pure declarations, no latency, no flow control.
package rv32_hart_scheduler_pkg;

    localparam int RV_NUM_HARTS = 8;
    localparam int RV_HART_ID_W = $clog2(RV_NUM_HARTS);

    typedef logic [RV_HART_ID_W-1:0] rv_hart_id_t;

    typedef enum logic [1:0] {
        RV_HART_IDLE = 2'd0,
        RV_HART_RUN  = 2'd1,
        RV_HART_TRAP = 2'd2
    } rv_hart_state_enum_t;

    // A trap only lands on a running hart and beats a simultaneous start.
    function automatic rv_hart_state_enum_t rv_hart_next(
        input rv_hart_state_enum_t cur,
        input logic                start,
        input logic                trap
    );
        rv_hart_state_enum_t nxt;
        nxt = cur;
        case (cur)
            RV_HART_IDLE: if (start) nxt = RV_HART_RUN;
            RV_HART_RUN:  if (trap)  nxt = RV_HART_TRAP;
            RV_HART_TRAP: if (start) nxt = RV_HART_RUN;
            default:      nxt = RV_HART_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rv32_rr_arbiter.sv
// Rotating-priority picker: grants the first set req bit at or above ptr, wrapping modulo N.
// Purely combinational, zero latency; no backpressure, requesters simply re-request.
module rv32_rr_arbiter #(
    parameter  int N    = 8,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            gnt_valid,
    output logic [ID_W-1:0] gnt_id
);

    logic [ID_W-1:0] idx;

    // Scan offsets from highest to lowest so the nearest requester after ptr is written last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ptr + ID_W'(k);
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = idx;
            end
        end
    end

endmodule

// File: rtl/rv32_hart_scheduler.sv
// Round-robin barrel scheduler: one eligible hart per cycle into fetch, parks harts on decoder traps.
// Issue is combinational from registered state; dec_* one cycle after issue, trap report one after that.
// No backpressure: stalled harts drop out of eligibility; RV32_SCHED_PERF_CNT_EN adds per-hart issue counters.
module rv32_hart_scheduler
    import rv32_hart_scheduler_pkg::*;
#(
    parameter  int NUM_HARTS = RV_NUM_HARTS,
    localparam int HART_ID_W = $clog2(NUM_HARTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NUM_HARTS-1:0] hart_start,
    input  logic [NUM_HARTS-1:0] hart_stall_req,
    input  logic                 instr_trap,
    output logic                 issue_valid,
    output logic [HART_ID_W-1:0] issue_hart_id,
    output logic                 dec_valid,
    output logic [HART_ID_W-1:0] dec_hart_id,
    output logic                 trap_valid,
    output logic [HART_ID_W-1:0] trap_hart_id,
    output logic [NUM_HARTS-1:0] hart_running
`ifdef RV32_SCHED_PERF_CNT_EN
    ,
    input  logic [HART_ID_W-1:0] perf_sel,
    input  logic                 perf_clr,
    output logic [31:0]          perf_cnt
`endif
);

    rv_hart_state_enum_t state_q [NUM_HARTS];
    rv_hart_state_enum_t state_d [NUM_HARTS];

    logic [NUM_HARTS-1:0] trap_hit;
    logic [NUM_HARTS-1:0] eligible;
    logic [HART_ID_W-1:0] rr_ptr;
    logic                 gnt_valid;
    logic [HART_ID_W-1:0] gnt_id;

    // The hart whose instruction traps is masked in the very cycle the trap is seen.
    always_comb begin
        for (int i = 0; i < NUM_HARTS; i++) begin
            trap_hit[i]     = dec_valid && instr_trap && (dec_hart_id == HART_ID_W'(i));
            eligible[i]     = (state_q[i] == RV_HART_RUN) && !hart_stall_req[i] && !trap_hit[i];
            hart_running[i] = (state_q[i] == RV_HART_RUN);
            state_d[i]      = rv_hart_next(state_q[i], hart_start[i], trap_hit[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_HARTS; i++) begin
                state_q[i] <= RV_HART_IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_HARTS; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    rv32_rr_arbiter #(
        .N (NUM_HARTS)
    ) u_arb (
        .req       (eligible),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        issue_valid   = enable && gnt_valid;
        issue_hart_id = issue_valid ? gnt_id : '0;
    end

    // Power-of-two hart count, so the +1 wraps from NUM_HARTS-1 to 0 by truncation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= '0;
            dec_valid    <= 1'b0;
            dec_hart_id  <= '0;
            trap_valid   <= 1'b0;
            trap_hart_id <= '0;
        end else begin
            if (issue_valid) begin
                rr_ptr <= issue_hart_id + HART_ID_W'(1);
            end
            dec_valid    <= issue_valid;
            dec_hart_id  <= issue_hart_id;
            trap_valid   <= dec_valid && instr_trap;
            trap_hart_id <= dec_hart_id;
        end
    end

`ifdef RV32_SCHED_PERF_CNT_EN
    logic [31:0] perf_cnt_q [NUM_HARTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_HARTS; i++) begin
                perf_cnt_q[i] <= '0;
            end
        end else if (perf_clr) begin
            for (int i = 0; i < NUM_HARTS; i++) begin
                perf_cnt_q[i] <= '0;
            end
        end else if (issue_valid) begin
            perf_cnt_q[issue_hart_id] <= perf_cnt_q[issue_hart_id] + 32'd1;
        end
    end

    assign perf_cnt = perf_cnt_q[perf_sel];
`endif

endmodule

// File: tb/tb_rv32_hart_scheduler.sv
// Directed bench for rv32_hart_scheduler with 8 harts; inputs change 1 time unit after the
// rising edge, outputs are checked 2 units after it.
module tb_rv32_hart_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] hart_start;
    logic [7:0] hart_stall_req;
    logic       instr_trap;
    logic       issue_valid;
    logic [2:0] issue_hart_id;
    logic       dec_valid;
    logic [2:0] dec_hart_id;
    logic       trap_valid;
    logic [2:0] trap_hart_id;
    logic [7:0] hart_running;
`ifdef RV32_SCHED_PERF_CNT_EN
    logic [2:0]  perf_sel;
    logic        perf_clr;
    logic [31:0] perf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32_hart_scheduler #(.NUM_HARTS(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .hart_start     (hart_start),
        .hart_stall_req (hart_stall_req),
        .instr_trap     (instr_trap),
        .issue_valid    (issue_valid),
        .issue_hart_id  (issue_hart_id),
        .dec_valid      (dec_valid),
        .dec_hart_id    (dec_hart_id),
        .trap_valid     (trap_valid),
        .trap_hart_id   (trap_hart_id),
        .hart_running   (hart_running)
`ifdef RV32_SCHED_PERF_CNT_EN
        ,
        .perf_sel       (perf_sel),
        .perf_clr       (perf_clr),
        .perf_cnt       (perf_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst            = 1'b1;
        enable         = 1'b0;
        hart_start     = 8'h00;
        hart_stall_req = 8'h00;
        instr_trap     = 1'b0;
        #2;
        rst            = 1'b0;
    endtask

    task automatic test_reset;
        rst            = 1'b1;
        enable         = 1'b0;
        hart_start     = 8'h00;
        hart_stall_req = 8'h00;
        instr_trap     = 1'b0;
`ifdef RV32_SCHED_PERF_CNT_EN
        perf_sel = 3'd0;
        perf_clr = 1'b0;
`endif
        tick();
        tick();
        checks++;
        if ({issue_valid, issue_hart_id, dec_valid, dec_hart_id, trap_valid, trap_hart_id} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {issue_valid, issue_hart_id, dec_valid, dec_hart_id, trap_valid, trap_hart_id});
        end
        checks++;
        if (hart_running !== 8'h00) begin
            errors++;
            $display("FAIL reset_running: got %h, want 00", hart_running);
        end
        rst = 1'b0;
        enable = 1'b1;
        tick();
        checks++;
        if (issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_issue: got %b, want 0", issue_valid);
        end
    endtask

    task automatic test_round_robin;
        logic [2:0] exp;
        do_reset();
        enable     = 1'b1;
        hart_start = 8'hFF;
        tick();
        hart_start = 8'h00;
        for (int k = 0; k < 9; k++) begin
            #1;
            exp = 3'(k % 8);
            checks++;
            if (issue_valid !== 1'b1 || issue_hart_id !== exp) begin
                errors++;
                $display("FAIL rr_issue[%0d]: got v=%b id=%0d, want v=1 id=%0d", k, issue_valid, issue_hart_id, exp);
            end
            checks++;
            if (dec_valid !== (k > 0) || (k > 0 && dec_hart_id !== 3'((k + 7) % 8))) begin
                errors++;
                $display("FAIL rr_dec[%0d]: got v=%b id=%0d, want v=%0d id=%0d", k, dec_valid, dec_hart_id, k > 0, (k + 7) % 8);
            end
            checks++;
            if (hart_running !== 8'hFF) begin
                errors++;
                $display("FAIL rr_running[%0d]: got %h, want ff", k, hart_running);
            end
            tick();
        end
    endtask

    task automatic test_stall;
        logic [2:0] exp;
        do_reset();
        enable         = 1'b1;
        hart_start     = 8'b0010_0100;
        hart_stall_req = 8'b0010_0000;
        tick();
        hart_start = 8'h00;
        for (int k = 0; k < 7; k++) begin
            if (k == 4) hart_stall_req = 8'h00;
            #1;
            exp = (k < 4) ? 3'd2 : ((k == 5) ? 3'd2 : 3'd5);
            checks++;
            if (issue_valid !== 1'b1 || issue_hart_id !== exp) begin
                errors++;
                $display("FAIL stall_issue[%0d]: got v=%b id=%0d, want v=1 id=%0d", k, issue_valid, issue_hart_id, exp);
            end
            tick();
        end
    endtask

    task automatic test_trap;
        do_reset();
        enable     = 1'b1;
        hart_start = 8'b0000_1000;
        tick();
        hart_start = 8'h00;
        #1;
        checks++;
        if (issue_valid !== 1'b1 || issue_hart_id !== 3'd3) begin
            errors++;
            $display("FAIL trap_first_issue: got v=%b id=%0d, want v=1 id=3", issue_valid, issue_hart_id);
        end
        tick();
        instr_trap = 1'b1;
        #1;
        checks++;
        if (dec_valid !== 1'b1 || dec_hart_id !== 3'd3 || issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL trap_mask: got dec_v=%b dec_id=%0d issue_v=%b, want 1 3 0", dec_valid, dec_hart_id, issue_valid);
        end
        tick();
        instr_trap = 1'b0;
        hart_start = 8'b0000_1000;
        #1;
        checks++;
        if (issue_valid !== 1'b0 || trap_valid !== 1'b1 || trap_hart_id !== 3'd3 || hart_running[3] !== 1'b0) begin
            errors++;
            $display("FAIL trap_report: got issue_v=%b trap_v=%b trap_id=%0d run3=%b, want 0 1 3 0",
                     issue_valid, trap_valid, trap_hart_id, hart_running[3]);
        end
        tick();
        hart_start = 8'h00;
        #1;
        checks++;
        if (issue_valid !== 1'b1 || issue_hart_id !== 3'd3 || trap_valid !== 1'b0 || hart_running !== 8'h08) begin
            errors++;
            $display("FAIL trap_restart: got issue_v=%b id=%0d trap_v=%b run=%h, want 1 3 0 08",
                     issue_valid, issue_hart_id, trap_valid, hart_running);
        end
        tick();
    endtask

    task automatic test_trap_start_same;
        do_reset();
        enable     = 1'b1;
        hart_start = 8'b0001_0000;
        tick();
        hart_start = 8'h00;
        tick();
        instr_trap = 1'b1;
        hart_start = 8'b0001_0000;
        #1;
        checks++;
        if (dec_hart_id !== 3'd4 || issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_mask: got dec_id=%0d issue_v=%b, want 4 0", dec_hart_id, issue_valid);
        end
        tick();
        instr_trap = 1'b0;
        hart_start = 8'h00;
        #1;
        checks++;
        if (hart_running !== 8'h00 || issue_valid !== 1'b0 || trap_valid !== 1'b1 || trap_hart_id !== 3'd4) begin
            errors++;
            $display("FAIL same_cycle_trap_wins: got run=%h issue_v=%b trap_v=%b trap_id=%0d, want 00 0 1 4",
                     hart_running, issue_valid, trap_valid, trap_hart_id);
        end
        tick();
    endtask

    task automatic test_enable_mid;
        do_reset();
        enable     = 1'b1;
        hart_start = 8'b0100_0010;
        tick();
        hart_start = 8'h00;
        #1;
        checks++;
        if (issue_valid !== 1'b1 || issue_hart_id !== 3'd1) begin
            errors++;
            $display("FAIL en_first: got v=%b id=%0d, want 1 1", issue_valid, issue_hart_id);
        end
        tick();
        enable     = 1'b0;
        instr_trap = 1'b1;
        #1;
        checks++;
        if (issue_valid !== 1'b0 || issue_hart_id !== 3'd0 || dec_valid !== 1'b1 || dec_hart_id !== 3'd1) begin
            errors++;
            $display("FAIL en_inflight: got issue_v=%b id=%0d dec_v=%b dec_id=%0d, want 0 0 1 1",
                     issue_valid, issue_hart_id, dec_valid, dec_hart_id);
        end
        tick();
        instr_trap = 1'b0;
        #1;
        checks++;
        if (dec_valid !== 1'b0 || trap_valid !== 1'b1 || trap_hart_id !== 3'd1 || hart_running !== 8'h40) begin
            errors++;
            $display("FAIL en_trap_honoured: got dec_v=%b trap_v=%b trap_id=%0d run=%h, want 0 1 1 40",
                     dec_valid, trap_valid, trap_hart_id, hart_running);
        end
        tick();
        enable = 1'b1;
        #1;
        checks++;
        if (issue_valid !== 1'b1 || issue_hart_id !== 3'd6) begin
            errors++;
            $display("FAIL en_resume: got v=%b id=%0d, want 1 6", issue_valid, issue_hart_id);
        end
        tick();
    endtask

    task automatic test_async_reset;
        do_reset();
        enable     = 1'b1;
        hart_start = 8'hFF;
        tick();
        hart_start = 8'h00;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({issue_valid, issue_hart_id, dec_valid, dec_hart_id, trap_valid, trap_hart_id} !== 12'h000
            || hart_running !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got outs=%b run=%h, want zero",
                     {issue_valid, issue_hart_id, dec_valid, dec_hart_id, trap_valid, trap_hart_id}, hart_running);
        end
        #1;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (issue_valid !== 1'b0 || dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_post_release: got issue_v=%b dec_v=%b, want 0 0", issue_valid, dec_valid);
        end
        hart_start = 8'h80;
        tick();
        hart_start = 8'h00;
        #1;
        checks++;
        if (issue_valid !== 1'b1 || issue_hart_id !== 3'd7) begin
            errors++;
            $display("FAIL async_restart: got v=%b id=%0d, want 1 7", issue_valid, issue_hart_id);
        end
        tick();
    endtask

`ifdef RV32_SCHED_PERF_CNT_EN
    task automatic test_perf;
        do_reset();
        perf_clr   = 1'b0;
        enable     = 1'b1;
        hart_start = 8'hFF;
        tick();
        hart_start = 8'h00;
        repeat (80) tick();
        enable = 1'b0;
        for (int s = 0; s < 8; s++) begin
            perf_sel = 3'(s);
            #1;
            checks++;
            if (perf_cnt !== 32'd10) begin
                errors++;
                $display("FAIL perf_cnt[%0d]: got %0d, want 10", s, perf_cnt);
            end
        end
        tick();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        perf_sel = 3'd5;
        #1;
        checks++;
        if (perf_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_clr: got %0d, want 0", perf_cnt);
        end
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_stall();
        test_trap();
        test_trap_start_same();
        test_enable_mid();
        test_async_reset();
`ifdef RV32_SCHED_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_hart_scheduler.md
Name: rv32_hart_scheduler

Overview:
- Round-robin barrel scheduler for the multi-hart RV32 core.
- Each cycle it selects one eligible hart to issue into fetch, and the fetched instruction feeds the 1-cycle registered decoder.
- It tracks per-hart run state and parks a hart when the decoder raises instr_trap for that hart's instruction.
- It sits between the hart control/debug logic and the fetch/decode front end.

Parameters:
- NUM_HARTS, 8, number of hardware threads; power of two, 2..16.
- HART_ID_W, $clog2(NUM_HARTS), hart index width; localparam, not overridable.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  global issue enable; when 0, no issue and pointer holds
- hart_start  in  NUM_HARTS  per-hart release pulse (IDLE/TRAP -> RUN)
- hart_stall_req  in  NUM_HARTS  level; hart waiting on memory, not eligible
- instr_trap  in  1  decoder trap flag; refers to the instruction tagged dec_hart_id
- issue_valid  out  1  a hart is issued this cycle
- issue_hart_id  out  HART_ID_W  issued hart, used for PC select
- dec_valid  out  1  decoder output valid, issue_valid delayed 1 cycle
- dec_hart_id  out  HART_ID_W  hart owning the current decoder output
- trap_valid  out  1  registered trap report pulse
- trap_hart_id  out  HART_ID_W  trapped hart
- hart_running  out  NUM_HARTS  1 where state == RUN

Behaviour:
- Per-hart FSM, encoded {IDLE=0, RUN=1, TRAP=2}; reset state IDLE.
  - IDLE -> RUN on hart_start[i].
  - RUN -> TRAP when dec_valid && instr_trap && dec_hart_id==i.
  - TRAP -> RUN on hart_start[i].
  - hart_start on a RUN hart: ignored.
  - Trap and hart_start for the same RUN hart in the same cycle: trap wins, hart goes to TRAP.
- Eligible[i] = (state==RUN) && !hart_stall_req[i] && !(dec_valid && instr_trap && dec_hart_id==i).
  - The trapping hart is therefore masked in the same cycle its trap is seen.
- Issue (combinational from registered state):
  - If enable and any eligible: issue_valid=1, and issue_hart_id = first eligible index scanning from rr_ptr upward, with wrap-around modulo NUM_HARTS.
  - Otherwise issue_valid=0 and issue_hart_id=0.
- rr_ptr register, reset 0.
  - On issue, rr_ptr <= issue_hart_id+1, wrapping from NUM_HARTS-1 to 0.
  - On no issue, it holds.
- Decode alignment, registered:
  - dec_valid <= issue_valid; dec_hart_id <= issue_hart_id.
  - Latency from issue to dec_* is exactly 1 cycle, matching the decoder.
- Trap report, registered:
  - trap_valid <= dec_valid && instr_trap; trap_hart_id <= dec_hart_id.
  - instr_trap is ignored when dec_valid==0.
- A single eligible hart may issue back-to-back every cycle.
- enable deasserted mid-operation: the in-flight dec_valid still completes next cycle and its trap is still honoured.
- Async rst at any time: all FSMs go to IDLE; rr_ptr, dec_valid, dec_hart_id, trap_valid, trap_hart_id all go to 0. issue_valid=0 while in reset.
- hart_running reset value: all 0.

Optional Feature:
- Macro: RV32_SCHED_PERF_CNT_EN.
- Defined:
  - Adds inputs perf_sel (HART_ID_W) and perf_clr (1), and output perf_cnt (32).
  - Per-hart 32-bit issue counters increment on each issue of that hart and wrap at 2^32.
  - perf_clr zeroes all counters synchronously; clear has priority over increment.
  - perf_cnt = counter[perf_sel], combinational.
  - Counters reset to 0 on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared types header gets:
  - rv_hart_id_t (logic[HART_ID_W-1:0]);
  - rv_hart_state_enum_t {RV_HART_IDLE, RV_HART_RUN, RV_HART_TRAP};
  - constant RV_NUM_HARTS=8.
- One sub-module: rv32_rr_arbiter.
  - Combinational rotating-priority picker: inputs req vector and ptr; outputs gnt_valid and gnt_id.
  - Reused later by the memory-port arbiter.

Test Plan (NUM_HARTS=8):
- Reset, then hart_start=8'hFF for 1 cycle, enable=1:
  - issue_hart_id sequence 0,1,...,7,0.
  - dec_hart_id is the same sequence 1 cycle later.
  - hart_running=8'hFF.
- Start only harts 2 and 5; hold hart_stall_req[5]=1 for 4 cycles:
  - hart 2 issues every cycle during the stall;
  - then the sequence alternates 5,2,5.
- Hart 3 running alone; drive instr_trap=1 when dec_hart_id==3:
  - next cycle issue_valid=0, trap_valid=1, trap_hart_id=3, hart_running[3]=0;
  - hart_start[3] restores issue the following cycle.
- Same cycle: instr_trap for hart 4 and hart_start[4]=1:
  - hart 4 ends in TRAP;
  - hart 4 is not issued in that cycle even if rr_ptr==4.
- Async rst asserted mid-stream between clock edges:
  - all outputs 0 immediately;
  - after release, no issue until hart_start.
- With RV32_SCHED_PERF_CNT_EN, 8 harts, 80 cycles:
  - perf_cnt=10 for each perf_sel;
  - perf_clr gives 0 the next cycle.
